// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - eight-digit seven-segment scan controller with per-frame input capture
module seg_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_led,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_en,
    input  logic [7:0]  blank_mask,
    output logic [2:0]  num,
    output logic [7:0]  seg,
    output logic        frame_done
);

    logic [DIV_W-1:0] div_cnt;
    logic             running;
    logic [31:0]      sh_digits;
    logic [7:0]       sh_dp;
    logic [7:0]       sh_blank;
    logic             tick;
    logic             capture;
    logic [2:0]       next_num;

    function automatic logic [7:0] seg_pattern(input logic [3:0] val, input logic dp, input logic blank);
        logic [7:0] pat;
        case (val)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        pat[7] = ~dp;
        if (blank) begin
            pat = 8'hFF;
        end
        return pat;
    endfunction

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign next_num = num + 3'd1;
    // A frame starts on the first powered edge or when digit 7's dwell expires.
    assign capture  = power_led && (!running || (tick && (num == 3'd7)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            num        <= 3'd0;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
            running    <= 1'b0;
            sh_digits  <= 32'd0;
            sh_dp      <= 8'd0;
            sh_blank   <= 8'hFF;
        end else if (!power_led) begin
            div_cnt    <= '0;
            num        <= 3'd0;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
            running    <= 1'b0;
        end else if (capture) begin
            // Digit 0 is decoded from the live inputs so it appears on the capture edge.
            running    <= 1'b1;
            div_cnt    <= '0;
            num        <= 3'd0;
            sh_digits  <= digits;
            sh_dp      <= dp_en;
            sh_blank   <= blank_mask;
            seg        <= seg_pattern(digits[3:0], dp_en[0], blank_mask[0]);
            frame_done <= 1'b1;
        end else if (tick) begin
            div_cnt    <= '0;
            num        <= next_num;
            seg        <= seg_pattern(sh_digits[{next_num, 2'b00} +: 4], sh_dp[next_num], sh_blank[next_num]);
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        power_led = 1'b0;
    logic [31:0] digits = 32'd0;
    logic [7:0]  dp_en = 8'd0;
    logic [7:0]  blank_mask = 8'd0;
    logic [2:0]  num;
    logic [7:0]  seg;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    seg_scan_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .power_led(power_led),
        .digits(digits),
        .dp_en(dp_en),
        .blank_mask(blank_mask),
        .num(num),
        .seg(seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: position within the frame in cycles, -1 when idle (unpowered or just reset).
    int          m_pos = -1;
    logic [3:0]  m_dig [8];
    logic [7:0]  m_dp = 8'd0;
    logic [7:0]  m_blank = 8'hFF;
    logic        m_fd = 1'b0;
    logic [7:0]  font [16];

    function automatic int exp_num();
        return (m_pos < 0) ? 0 : m_pos / D;
    endfunction

    function automatic logic [7:0] exp_seg();
        int n;
        logic [7:0] s;
        if (m_pos < 0) return 8'hFF;
        n = m_pos / D;
        if (m_blank[n]) return 8'hFF;
        s = font[m_dig[n]];
        s[7] = ~m_dp[n];
        return s;
    endfunction

    task automatic model_reset();
        m_pos = -1;
        m_fd = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!power_led) begin
            m_pos = -1;
            m_fd = 1'b0;
        end else if (m_pos < 0 || m_pos == 8 * D - 1) begin
            m_pos = 0;
            m_fd = 1'b1;
            for (int i = 0; i < 8; i++) m_dig[i] = digits[4*i +: 4];
            m_dp = dp_en;
            m_blank = blank_mask;
        end else begin
            m_pos++;
            m_fd = 1'b0;
        end
    endtask

    task automatic check3(input string name, input int n_exp, input logic [7:0] s_exp, input logic f_exp);
        checks++;
        if (num !== 3'(n_exp) || seg !== s_exp || frame_done !== f_exp) begin
            errors++;
            $display("FAIL %s: got num=%0d seg=%02h fd=%0b, want num=%0d seg=%02h fd=%0b",
                     name, num, seg, frame_done, n_exp, s_exp, f_exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check3(name, exp_num(), exp_seg(), m_fd);
    endtask

    typedef struct {
        logic        pwr;
        logic [31:0] dig;
        logic [7:0]  dp;
        logic [7:0]  blank;
        int          cycles;
        int          e_num;
        logic [7:0]  e_seg;
        logic        e_fd;
    } vec_t;

    vec_t vecs [21];

    initial begin
        font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;

        vecs[0]  = '{1'b1, 32'h76543210, 8'h00, 8'h00, 1,  0, 8'hC0, 1'b1};
        vecs[1]  = '{1'b1, 32'h76543210, 8'h00, 8'h00, 1,  0, 8'hC0, 1'b0};
        vecs[2]  = '{1'b1, 32'h76543210, 8'h00, 8'h00, 3,  1, 8'hF9, 1'b0};
        vecs[3]  = '{1'b1, 32'h76543210, 8'h00, 8'h00, 4,  2, 8'hA4, 1'b0};
        vecs[4]  = '{1'b1, 32'h76543210, 8'h00, 8'h00, 4,  3, 8'hB0, 1'b0};
        vecs[5]  = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  4, 8'h99, 1'b0};
        vecs[6]  = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  5, 8'h92, 1'b0};
        vecs[7]  = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  6, 8'h82, 1'b0};
        vecs[8]  = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  7, 8'hF8, 1'b0};
        vecs[9]  = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  0, 8'h80, 1'b1};
        vecs[10] = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  1, 8'h90, 1'b0};
        vecs[11] = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  2, 8'h88, 1'b0};
        vecs[12] = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  3, 8'h83, 1'b0};
        vecs[13] = '{1'b1, 32'hFEDCBA98, 8'h00, 8'h00, 4,  4, 8'hC6, 1'b0};
        vecs[14] = '{1'b1, 32'hFEDCBA98, 8'h01, 8'h80, 16, 0, 8'h00, 1'b1};
        vecs[15] = '{1'b1, 32'hFEDCBA98, 8'h01, 8'h80, 28, 7, 8'hFF, 1'b0};
        vecs[16] = '{1'b1, 32'hFEDCBA98, 8'h01, 8'h80, 24, 5, 8'hA1, 1'b0};
        vecs[17] = '{1'b0, 32'hFEDCBA98, 8'h01, 8'h80, 1,  0, 8'hFF, 1'b0};
        vecs[18] = '{1'b0, 32'hFEDCBA98, 8'h01, 8'h80, 5,  0, 8'hFF, 1'b0};
        vecs[19] = '{1'b1, 32'h76543210, 8'h00, 8'h00, 1,  0, 8'hC0, 1'b1};
        vecs[20] = '{1'b1, 32'h76543210, 8'h00, 8'h00, 4,  1, 8'hF9, 1'b0};

        #12;
        check3("reset_hold", 0, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("idle_unpowered");

        for (int v = 0; v < 21; v++) begin
            @(negedge clk);
            power_led  = vecs[v].pwr;
            digits     = vecs[v].dig;
            dp_en      = vecs[v].dp;
            blank_mask = vecs[v].blank;
            for (int c = 0; c < vecs[v].cycles; c++) step("vec_model");
            check3($sformatf("vec%0d", v), vecs[v].e_num, vecs[v].e_seg, vecs[v].e_fd);
        end

        // Async reset between edges while digit 6 is lit.
        begin
            int budget = 0;
            while (exp_num() != 6 && budget < 100) begin
                step("seek_digit6");
                budget++;
            end
            checks++;
            if (budget >= 100) begin
                errors++;
                $display("FAIL seek_digit6: timeout got num=%0d want 6", num);
            end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 check3("async_reset", 0, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_capture");
        check3("post_reset_capture_fixed", 0, 8'hC0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            power_led  = ($urandom_range(0, 99) < 97);
            digits     = $urandom;
            dp_en      = 8'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Generates the 3-bit digit index `num` for the downstream 3-to-8 digit-select decoder. That decoder takes `num` plus `power_led` and drives active-low selects.
- Also produces the matching active-low segment pattern for the digit currently selected.
- Display data is double-buffered per frame, so a digit value never changes while that digit is lit.

Parameters:
- CLK_DIV, 100000, clk cycles each digit stays lit; min 2. Default gives 1 kHz per digit / 125 Hz frame at 100 MHz.
- DIV_W, $clog2(CLK_DIV), width of the prescaler counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- power_led  input  1  display enable; 0 = display off. Same signal feeds the digit-select decoder.
- digits  input  32  eight hex nibbles; digits[4n+3:4n] is the value for digit n.
- dp_en  input  8  decimal point request per digit, 1 = lit.
- blank_mask  input  8  1 = digit n shows nothing (segments all off).
- num  output  3  current digit index 0..7, registered; goes to the digit-select decoder.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered, aligned with num.
- frame_done  output  1  one-cycle pulse when a new frame starts and inputs are captured.

Behaviour:
- Reset (rst_n=0, async) values:
  - div_cnt=0, num=0, seg=8'hFF, frame_done=0.
  - Shadow regs sh_digits=0, sh_dp=0, sh_blank=8'hFF.
- Prescaler:
  - div_cnt increments each cycle while power_led=1.
  - tick is asserted when div_cnt==CLK_DIV-1; div_cnt then wraps to 0.
- Scan:
  - On tick, num <= num+1 mod 8 (7 wraps to 0).
  - Each digit is held exactly CLK_DIV cycles.
- Frame capture:
  - On a tick that wraps num 7->0: sh_digits<=digits, sh_dp<=dp_en, sh_blank<=blank_mask, and frame_done=1 for that one cycle.
  - Inputs are ignored at all other times.
- Segment output:
  - seg updates on the same edge as num, so seg always corresponds to the registered num.
  - Zero latency between index and pattern.
  - At the 7->0 wrap, seg for digit 0 is computed from the freshly sampled inputs, not the old shadow.
- Decode (active-low, dp bit=1):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8.
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E.
  - Then seg[7] = ~dp of that digit.
  - If the blank bit for that digit is set, seg=8'hFF regardless of value or dp.
- Power off (power_led=0):
  - Synchronous, next edge: div_cnt<=0, num<=0, seg<=8'hFF, frame_done<=0.
  - Shadows hold their values.
- Power on (power_led 0->1):
  - First edge with power_led=1 loads the shadows from the inputs and pulses frame_done.
  - On that edge seg takes the digit-0 pattern, num stays 0 and div_cnt starts counting.
  - Digit 0 is therefore shown a full CLK_DIV cycles after power-on.
- Decoder blanking: the downstream decoder blanks positions 2 and 5 itself. This block still scans all 8 indices with uniform dwell; no skipping.
- Reset mid-frame: everything returns to reset values immediately. The first frame after reset starts at num=0 with a capture, as for power-on (if power_led=1).
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: CLK_DIV=4, hold rst_n=0 -> num=0, seg=FF, frame_done=0. Release with power_led=0 -> outputs unchanged for 20 cycles.
- Power-on capture:
  - Stimulus: digits=32'h76543210, dp_en=0, blank_mask=0, raise power_led.
  - Next edge: frame_done=1, num=0, seg=C0.
  - Then every 4 cycles num steps 1..7 with seg=F9,A4,B0,99,92,82,F8.
  - After 7, num wraps to 0 with frame_done=1.
- Double buffering:
  - Stimulus: change digits to 32'hFEDCBA98 while num=3.
  - Digits 4..7 still show 99,92,82,F8.
  - At the wrap: frame_done pulses and seg=80; the next digits show 90,88,83,C6.
- DP and blank: dp_en=8'h01, blank_mask=8'h80, digits nibble0=8 -> num=0 seg=00; num=7 seg=FF.
- Power-off mid-frame: drop power_led at num=5 -> next edge num=0, seg=FF, div_cnt=0. Re-raise -> capture pulse and seg restarts at digit 0.
- Async reset mid-dwell: assert rst_n low between clk edges at num=6 -> num=0 and seg=FF immediately, without waiting for a clock edge.
